// File: rtl/riscv_pkg.sv
// Purpose : shared RV32 definitions used by the M-extension multiply/divide sequencer.
// Latency : n/a (types, constants and pure helper functions only).
// Backpr. : n/a.
// Contents: ARCH_LEN, MULDIV_FUNCT7, muldiv_op_e (funct3 encodings),
//           muldiv_state_e (sequencer FSM states), operand signedness helpers.
package riscv_pkg;

  localparam int         ARCH_LEN      = 32;
  // funct7 that decode/issue uses to divert an OP-class instruction to the sequencer.
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  // rs1 is treated as two's complement for every signed flavour, including MULHSU.
  function automatic logic op1_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is unsigned for MULHSU as well as for the explicitly unsigned ops.
  function automatic logic op2_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Purpose : one iteration of the shift-add multiplier or restoring divider on {acc, opr}.
// Latency : combinational, zero cycles.
// Backpr. : none; the caller decides when to register the outputs.
// Ports   : i_is_div selects divide; i_acc/i_opr are the current accumulator and
//           multiplier/quotient register; i_m is the multiplicand or divisor magnitude;
//           o_acc/o_opr are the values after this step.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opr,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_opr
);

  logic [WIDTH:0] w_sum;  // multiply: acc + (opr[0] ? m : 0), carry kept
  logic [WIDTH:0] w_shl;  // divide: partial remainder shifted left with next dividend bit
  logic           w_ge;   // divide: trial subtraction succeeds

  always_comb begin
    w_sum = {1'b0, i_acc} + (i_opr[0] ? {1'b0, i_m} : '0);
    w_shl = {i_acc, i_opr[WIDTH-1]};
    w_ge  = (w_shl >= {1'b0, i_m});
    o_acc = '0;
    o_opr = '0;
    if (i_is_div) begin
      // When the trial succeeds the true difference is below the divisor, so the
      // modulo-2^WIDTH subtraction is exact; when it fails w_shl[WIDTH] is zero.
      o_acc = w_ge ? (w_shl[WIDTH-1:0] - i_m) : w_shl[WIDTH-1:0];
      o_opr = {i_opr[WIDTH-2:0], w_ge};
    end else begin
      // Product accumulates in acc and shifts down into opr as multiplier bits retire.
      o_acc = w_sum[WIDTH:1];
      o_opr = {w_sum[0], i_opr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Purpose : iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU sequencer.
// Latency : out_valid first high WIDTH+2 cycles after the accept cycle (cycle 0);
//           with MULDIV_EARLY_OUT_EN defined, zero-operand / divide-by-zero cases finish in 1.
// Backpr. : in_ready only in IDLE; result and out_valid hold in DONE until out_ready.
// Ports   : clk, rst (async active-low), flush (kill in-flight op, beats accept/out_ready),
//           in_valid/in_ready + op/operand1/operand2 request, out_valid/out_ready + result,
//           busy (state != IDLE).
// Config  : `define MULDIV_EARLY_OUT_EN to enable the early-out path.
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int WIDTH = ARCH_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_FIX  = FIX;
  localparam logic [1:0] S_DONE = DONE;

  // ---------------------------------------------------------------- state
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_neg;     // final result must be negated
  logic [WIDTH-1:0] r_acc;     // product high half / partial remainder
  logic [WIDTH-1:0] r_opr;     // product low half / quotient (starts as |rs1|)
  logic [WIDTH-1:0] r_m;       // |rs2|: multiplicand or divisor
  logic [WIDTH-1:0] r_result;
  logic             r_out_vld;

  // ---------------------------------------------------------------- accept-side decode
  logic             w_accept;
  logic             w_s1;
  logic             w_s2;
  logic             w_div0;
  logic             w_neg;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;

  // flush wins over a simultaneous request in IDLE.
  assign w_accept = in_valid && (r_state == S_IDLE) && !flush;

  always_comb begin
    w_s1   = op1_signed(op) & operand1[WIDTH-1];
    w_s2   = op2_signed(op) & operand2[WIDTH-1];
    w_div0 = (operand2 == '0);
    w_mag1 = w_s1 ? -operand1 : operand1;
    w_mag2 = w_s2 ? -operand2 : operand2;
    w_neg  = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU: w_neg = w_s1 ^ w_s2;
      // Divide by zero leaves the all-ones quotient un-negated.
      OP_DIV:                     w_neg = (w_s1 ^ w_s2) & ~w_div0;
      // Remainder follows the dividend; for divide by zero this rebuilds rs1 exactly.
      OP_REM:                     w_neg = w_s1;
      default:                    w_neg = 1'b0;
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic             w_early;
  logic [WIDTH-1:0] w_early_res;

  always_comb begin
    w_early     = op[2] ? w_div0 : ((operand1 == '0) || w_div0);
    // op[1] separates REM* from DIV*; every multiply by zero yields zero.
    w_early_res = op[2] ? (op[1] ? operand1 : '1) : '0;
  end
`endif

  // ---------------------------------------------------------------- iteration datapath
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_opr_nxt;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_is_div (r_op[2]),
    .i_acc    (r_acc),
    .i_opr    (r_opr),
    .i_m      (r_m),
    .o_acc    (w_acc_nxt),
    .o_opr    (w_opr_nxt)
  );

  // ---------------------------------------------------------------- sign fix / result select
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_div_sel;
  logic [WIDTH-1:0]   w_div_fix;
  logic [WIDTH-1:0]   w_fix_res;

  always_comb begin
    w_prod     = {r_acc, r_opr};
    // Negate the full double-width product so the high half borrows correctly.
    w_prod_fix = r_neg ? -w_prod : w_prod;
    w_div_sel  = r_op[1] ? r_acc : r_opr;
    w_div_fix  = r_neg ? -w_div_sel : w_div_sel;
    if (r_op[2]) begin
      w_fix_res = w_div_fix;
    end else if (r_op[1:0] == 2'b00) begin
      w_fix_res = w_prod_fix[WIDTH-1:0];
    end else begin
      w_fix_res = w_prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_opr     <= '0;
      r_m       <= '0;
      r_result  <= '0;
      r_out_vld <= 1'b0;
    end else if (flush) begin
      // Result register intentionally keeps its last value.
      r_state   <= S_IDLE;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_neg <= w_neg;
            r_acc <= '0;
            r_opr <= w_mag1;
            r_m   <= w_mag2;
            r_cnt <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_early) begin
              r_result  <= w_early_res;
              r_out_vld <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state   <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_opr <= w_opr_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result  <= w_fix_res;
          r_out_vld <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_out_vld <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_vld;
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Purpose : self-checking bench for muldiv_seq with a result scoreboard.
// Latency : expects WIDTH+2 cycles per op (1 for zero cases when MULDIV_EARLY_OUT_EN is set).
// Backpr. : exercises out_ready hold, flush and mid-op reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int          n_err;
  int          n_chk;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  muldiv_seq #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit signed integers.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0:    begin p = sa * sb; return p[31:0];  end
      3'd1:    begin p = sa * sb; return p[63:32]; end
      3'd2:    begin p = sa * ub; return p[63:32]; end
      3'd3:    begin p = ua * ub; return p[63:32]; end
      3'd4:    return (b == 32'd0) ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd5:    return (b == 32'd0) ? 32'hFFFFFFFF : 32'(ua / ub);
      3'd6:    return (b == 32'd0) ? a : 32'(sa % sb);
      default: return (b == 32'd0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // Drives one request; returns at the falling edge of cycle 1 (accept cycle = 0).
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check_val("in_ready_before_accept", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    op       = o;
    operand1 = a;
    operand2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    // Later operand changes must not disturb the op in flight.
    op       = 3'($urandom_range(0, 7));
    operand1 = $urandom;
    operand2 = $urandom;
  endtask

  // Waits (bounded) for out_valid, pops the scoreboard, compares, then releases the result.
  task automatic finish_op(input string tag, input int exp_lat);
    int          lat;
    logic [31:0] exp;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_vld"}, 64'(out_valid), 64'(1));
    exp = exp_q.pop_front();
    check_val(tag, 64'(result), 64'(exp));
    if (exp_lat != 0) check_val({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    last_exp  = exp;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_released"}, 64'(out_valid), 64'(0));
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    exp_q.push_back(exp);
    start_op(o, a, b);
    finish_op(tag, exp_lat);
  endtask

  initial begin
    int          seen;
    logic [31:0] hold_val;
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    n_err     = 0;
    n_chk     = 0;
    last_exp  = 32'h0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'd0;
    operand1  = 32'h0;
    operand2  = 32'h0;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_result",    64'(result),    64'(0));
    check_val("rst_busy",      64'(busy),      64'(0));
    check_val("rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1'b1;

    // ---------------- directed vectors
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34,   "mul_7x-3");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34,   "mulh_min");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34,   "mulhsu");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34,   "mulhu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34,   "div_-7/2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34,   "rem_-7/2");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34,   "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34,   "rem_ovf");
    run_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, ZLAT, "divu_by0");
    run_op(3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, ZLAT, "rem_by0");
    run_op(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, ZLAT, "div_by0_neg");
    run_op(3'd1, 32'd0,        32'h12345678, 32'h00000000, ZLAT, "mulh_zero");

    // ---------------- flush at cycle 10 of a DIV
    start_op(3'd4, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flush_in_ready",  64'(in_ready),  64'(1));
    check_val("flush_busy",      64'(busy),      64'(0));
    check_val("flush_out_valid", 64'(out_valid), 64'(0));
    check_val("flush_result_kept", 64'(result), 64'(last_exp));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("flush_never_valid", 64'(seen), 64'(0));
    // Request coinciding with flush in IDLE is dropped.
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 3'd0;
    operand1 = 32'd9;
    operand2 = 32'd9;
    @(negedge clk);
    check_val("flush_blocks_accept", 64'(busy), 64'(0));
    flush    = 1'b0;
    in_valid = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush");

    // ---------------- DONE hold with out_ready low for 5 cycles
    exp_q.push_back(32'h0000_0007);
    start_op(3'd5, 32'd100, 32'd14);
    for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
    hold_val = exp_q.pop_front();
    check_val("hold_first", 64'(result), 64'(hold_val));
    in_valid = 1'b1;
    op       = 3'd0;
    operand1 = 32'd3;
    operand2 = 32'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("hold_result",    64'(result),    64'(hold_val));
      check_val("hold_out_valid", 64'(out_valid), 64'(1));
      check_val("hold_in_ready",  64'(in_ready),  64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("release_in_ready",  64'(in_ready),  64'(1));
    check_val("release_out_valid", 64'(out_valid), 64'(0));
    exp_q.push_back(32'd15);
    @(negedge clk);
    check_val("accept_after_release", 64'(busy), 64'(1));
    in_valid = 1'b0;
    finish_op("mul_3x5_after_hold", 34);

    // ---------------- reset at cycle 20 of a MUL
    start_op(3'd0, 32'd12345, 32'd678);
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(out_valid), 64'(0));
    check_val("midrst_busy",      64'(busy),      64'(0));
    check_val("midrst_in_ready",  64'(in_ready),  64'(1));
    check_val("midrst_result",    64'(result),    64'(0));
    @(negedge clk);
    rst = 1'b1;
    run_op(3'd0, 32'd12345, 32'd678, 32'd8369910, 34, "mul_after_rst");

    // ---------------- randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, ref_model(ro, ra, rb), 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
